// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small synchronous FIFO.
//
// Ports:
//   clk          - sole clock, rising edge
//   reset        - synchronous, active-high reset
//   wr_uart      - one-cycle write strobe for w_data
//   w_data       - byte to transmit (DBIT bits)
//   tx           - registered serial line, idle high
//   tx_full      - FIFO full (registered)
//   tx_empty     - FIFO empty (registered)
//   tx_busy      - high whenever the FSM is not in IDLE
//   tx_done_tick - one-cycle pulse in the IDLE cycle that ends a frame
//
// Build option: define UART_TX_PARITY_EN to add an even-parity bit
// between the last data bit and the stop bit.
module uart_tx_fifo #(
  parameter int unsigned DBIT     = 8,
  parameter int unsigned SB_TICK  = 16,
  parameter int unsigned DVSR     = 163,
  parameter int unsigned DVSR_BIT = 8,
  parameter int unsigned FIFO_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_uart,
  input  logic [DBIT-1:0] w_data,
  output logic            tx,
  output logic            tx_full,
  output logic            tx_empty,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int unsigned DEPTH = 1 << FIFO_W;
  localparam int unsigned S_MAX = (SB_TICK > 16) ? SB_TICK : 16;
  localparam int unsigned S_W   = $clog2(S_MAX);
  localparam int unsigned N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef UART_TX_PARITY_EN
  localparam int unsigned ST_W = 3;
`else
  localparam int unsigned ST_W = 2;
`endif

  localparam logic [ST_W-1:0] IDLE   = ST_W'(0);
  localparam logic [ST_W-1:0] START  = ST_W'(1);
  localparam logic [ST_W-1:0] DATA   = ST_W'(2);
  localparam logic [ST_W-1:0] STOP   = ST_W'(3);
`ifdef UART_TX_PARITY_EN
  localparam logic [ST_W-1:0] PARITY = ST_W'(4);
`endif

  // FIFO storage and pointers
  logic [DBIT-1:0]   mem_q [DEPTH];
  logic [FIFO_W-1:0] w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
  logic [FIFO_W-1:0] w_succ_c, r_succ_c;
  logic              full_q, full_d, empty_q, empty_d;
  logic              push_c, pop_c;

  // Transmitter state
  logic [ST_W-1:0]     state_q, state_d;
  logic [DVSR_BIT-1:0] cnt_q, cnt_d;
  logic [S_W-1:0]      s_q, s_d;
  logic [N_W-1:0]      n_q, n_d;
  logic [DBIT-1:0]     b_q, b_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                s_tick_c;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  // The FSM pops whenever it sits in IDLE with data waiting; a write to a
  // full FIFO is only accepted when that pop frees a slot in the same cycle.
  assign pop_c    = (state_q == IDLE) && !empty_q;
  assign push_c   = wr_uart && (!full_q || pop_c);
  assign w_succ_c = w_ptr_q + 1'b1;
  assign r_succ_c = r_ptr_q + 1'b1;
  assign s_tick_c = (cnt_q == DVSR_BIT'(DVSR - 1));

  // FIFO pointer and flag update
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    case ({push_c, pop_c})
      2'b10: begin
        w_ptr_d = w_succ_c;
        empty_d = 1'b0;
        full_d  = (w_succ_c == r_ptr_q);
      end
      2'b01: begin
        r_ptr_d = r_succ_c;
        full_d  = 1'b0;
        empty_d = (r_succ_c == w_ptr_q);
      end
      2'b11: begin
        w_ptr_d = w_succ_c;
        r_ptr_d = r_succ_c;
      end
      default: ;
    endcase
  end

  // Next-state and output logic for the transmitter
  always_comb begin
    state_d = state_q;
    cnt_d   = s_tick_c ? '0 : cnt_q + 1'b1;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          state_d = START;
          b_d     = mem_q[r_ptr_q];
          s_d     = '0;
          cnt_d   = '0;  // start bit is timed from the pop edge
`ifdef UART_TX_PARITY_EN
          par_d   = ^mem_q[r_ptr_q];
`endif
        end
      end
      START: begin
        if (s_tick_c) begin
          if (s_q == S_W'(15)) begin
            state_d = DATA;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick_c) begin
          if (s_q == S_W'(15)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick_c) begin
          if (s_q == S_W'(15)) begin
            state_d = STOP;
            s_d     = '0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick_c) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx follows the state being entered so the line changes with the state
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // FIFO storage; contents need no reset since the pointers gate reads
  always_ff @(posedge clk) begin
    if (!reset && push_c) begin
      mem_q[w_ptr_q] <= w_data;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign tx_full      = full_q;
  assign tx_empty     = empty_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo with a shortened baud divider (DVSR=5, so one
// bit lasts 80 clocks); frame timing checks scale with BIT_CLKS.
module tb_uart_tx_fifo;

  localparam int DVSR     = 5;
  localparam int BIT_CLKS = 16 * DVSR;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * BIT_CLKS;

  logic       clk;
  logic       reset;
  logic       wr_uart;
  logic [7:0] w_data;
  logic       tx, tx_full, tx_empty, tx_busy, tx_done_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  uart_tx_fifo #(
    .DBIT(8), .SB_TICK(16), .DVSR(DVSR), .DVSR_BIT(8), .FIFO_W(2)
  ) dut (
    .clk(clk), .reset(reset), .wr_uart(wr_uart), .w_data(w_data),
    .tx(tx), .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] data;
    logic       tx;
    logic       full;
    logic       empty;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Checks a whole frame cycle by cycle, then the IDLE cycle that ends it.
  // pre = number of start-bit cycles already sampled (0: wait for start).
  task automatic check_frame(input logic [7:0] exp, input int pre,
                             output int waited, output int done_cyc);
    logic fb [NB];
    int   badbit [NB];
    int   badctl;
    int   p;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = exp[i];
`ifdef UART_TX_PARITY_EN
    fb[9] = ^exp;
`endif
    fb[NB-1] = 1'b1;
    for (int i = 0; i < NB; i++) badbit[i] = 0;
    badctl   = 0;
    waited   = 0;
    done_cyc = 0;
    p        = pre;
    if (p == 0) begin
      while (tx !== 1'b0 && waited < 4 * FRAME) begin
        step();
        waited++;
      end
      chk($sformatf("start_seen_%02h", exp), 32'(tx), 32'(0));
      if (tx !== 1'b0) return;
      p = 1;
    end
    for (int c = p - 1; c < FRAME; c++) begin
      if (c != p - 1) step();
      if (tx !== fb[c / BIT_CLKS]) badbit[c / BIT_CLKS]++;
      if (tx_done_tick !== 1'b0 || tx_busy !== 1'b1) badctl++;
    end
    for (int i = 0; i < NB; i++)
      chk($sformatf("frame_%02h_bit%0d_bad_cycles", exp, i), 32'(badbit[i]), 32'(0));
    chk($sformatf("frame_%02h_ctl_bad_cycles", exp), 32'(badctl), 32'(0));
    step();
    chk($sformatf("frame_%02h_idle_tx", exp), 32'(tx), 32'(1));
    chk($sformatf("frame_%02h_done", exp), 32'(tx_done_tick), 32'(1));
    chk($sformatf("frame_%02h_idle_busy", exp), 32'(tx_busy), 32'(0));
    done_cyc = cyc;
  endtask

  initial begin
    int         w, d0, d1, bad;
    logic [7:0] seq [$];

    reset   = 1'b1;
    wr_uart = 1'b0;
    w_data  = 8'h00;

    //          rst   wr    data   tx    full  empty busy  done
    vecs[0] = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    step();
    step();

    // Reset, write-under-reset, first write/pop latency, fill and overflow
    for (int i = 0; i < 10; i++) begin
      reset   = vecs[i].rst;
      wr_uart = vecs[i].wr;
      w_data  = vecs[i].data;
      step();
      chk($sformatf("v%0d_tx", i),    32'(tx),           32'(vecs[i].tx));
      chk($sformatf("v%0d_full", i),  32'(tx_full),      32'(vecs[i].full));
      chk($sformatf("v%0d_empty", i), 32'(tx_empty),     32'(vecs[i].empty));
      chk($sformatf("v%0d_busy", i),  32'(tx_busy),      32'(vecs[i].busy));
      chk($sformatf("v%0d_done", i),  32'(tx_done_tick), 32'(vecs[i].done));
    end
    wr_uart = 1'b0;

    // 0xA5 frame (7 start cycles already seen), then 01..04 back to back
    check_frame(8'hA5, 7, w, d0);
    seq = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (seq[i]) begin
      check_frame(seq[i], 0, w, d1);
      chk($sformatf("gap_before_%02h", seq[i]), 32'(w), 32'(1));
      chk($sformatf("done_spacing_%02h", seq[i]), 32'(d1 - d0), 32'(FRAME + 1));
      d0 = d1;
    end
    chk("empty_after_04", 32'(tx_empty), 32'(1));
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    chk("stays_idle", 32'(bad), 32'(0));

    // Fill the FIFO, then write 0x3C on the cycle the FSM pops
    seq = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    foreach (seq[i]) begin
      wr_uart = 1'b1;
      w_data  = seq[i];
      step();
    end
    wr_uart = 1'b0;
    chk("full_after_fill", 32'(tx_full), 32'(1));
    check_frame(8'h10, 4, w, d0);
    wr_uart = 1'b1;
    w_data  = 8'h3C;
    step();
    wr_uart = 1'b0;
    chk("full_after_pop_write", 32'(tx_full), 32'(1));
    chk("start_20", 32'(tx), 32'(0));
    check_frame(8'h20, 1, w, d0);
    seq = '{8'h30, 8'h40, 8'h50, 8'h3C};
    foreach (seq[i]) begin
      check_frame(seq[i], 0, w, d1);
      chk($sformatf("gap_before_%02h", seq[i]), 32'(w), 32'(1));
    end
    chk("empty_after_3c", 32'(tx_empty), 32'(1));

    // Reset in the middle of a 0xFF frame with another byte queued
    wr_uart = 1'b1;
    w_data  = 8'hFF;
    step();
    w_data  = 8'h00;
    step();
    wr_uart = 1'b0;
    chk("ff_started", 32'(tx), 32'(0));
    for (int i = 0; i < 3 * BIT_CLKS + 66; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_busy", 32'(tx_busy), 32'(0));
    chk("rst_empty", 32'(tx_empty), 32'(1));
    chk("rst_full", 32'(tx_full), 32'(0));
    chk("rst_done", 32'(tx_done_tick), 32'(0));
    bad = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      step();
      if (tx !== 1'b1 || tx_done_tick !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    chk("rst_quiet_after", 32'(bad), 32'(0));

    // Reset during a start bit must raise tx immediately
    wr_uart = 1'b1;
    w_data  = 8'h00;
    step();
    wr_uart = 1'b0;
    step();
    chk("start_00", 32'(tx), 32'(0));
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_start_tx", 32'(tx), 32'(1));
    chk("rst_start_busy", 32'(tx_busy), 32'(0));

    // Odd and even parity data patterns
    seq = '{8'h07, 8'h03};
    foreach (seq[i]) begin
      wr_uart = 1'b1;
      w_data  = seq[i];
      step();
      wr_uart = 1'b0;
      check_frame(seq[i], 0, w, d1);
      chk($sformatf("latency_%02h", seq[i]), 32'(w), 32'(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
